// File: rtl/vecrf_pkg.sv
// Package for the vector register file.
// Holds the FSM state encoding and two lane helpers shared by the storage
// array and the read ports. The helpers work on a fixed maximum width; the
// caller zero-extends its operands and truncates the result back to
// LANES*ELEM_WIDTH.
//   init_vec(ew, lanes)                    : vector with every element = 1
//   lane_merge(old, new, mask, ew, lanes)  : lanes with mask=1 take new, others keep old
package vecrf_pkg;

    localparam int MAX_VEC_W = 1024;
    localparam int MAX_LANES = 256;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_INIT = 1'b1;

    function automatic logic [MAX_VEC_W-1:0] init_vec(input int ew, input int lanes);
        logic [MAX_VEC_W-1:0] v;
        v = '0;
        for (int i = 0; i < lanes; i++) begin
            v = v | (MAX_VEC_W'(1) << (i * ew));
        end
        return v;
    endfunction

    function automatic logic [MAX_VEC_W-1:0] lane_merge(
        input logic [MAX_VEC_W-1:0] old_v,
        input logic [MAX_VEC_W-1:0] new_v,
        input logic [MAX_LANES-1:0] mask,
        input int                   ew,
        input int                   lanes
    );
        logic [MAX_VEC_W-1:0] r;
        logic [MAX_VEC_W-1:0] lane_ones;
        logic [MAX_VEC_W-1:0] lm;
        r         = old_v;
        lane_ones = (MAX_VEC_W'(1) << ew) - MAX_VEC_W'(1);
        for (int i = 0; i < lanes; i++) begin
            if (((mask >> i) & MAX_LANES'(1)) != '0) begin
                lm = lane_ones << (i * ew);
                r  = (r & ~lm) | (new_v & lm);
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/vecrf_read_port.sv
// One registered read port of the vector register file.
// Selects an entry from the flattened storage, overlays the write that is
// committing in the same cycle (bypass), and registers data and valid.
// Ports:
//   clk, reset            clock, asynchronous active-high reset
//   rd_en, rd_addr        read request and entry
//   mem_flat              all entries, entry i at [i*VW +: VW]
//   cm_en/addr/mask/data  the write committing at this edge (normal or init)
//   rd_data, rd_valid     registered result
// Handshake: rd_en sampled at edge N produces rd_valid=1 and rd_data during
// the cycle after edge N; there is no back-pressure. With rd_en=0, rd_valid
// drops and rd_data keeps the last returned value.
module vecrf_read_port
    import vecrf_pkg::*;
#(
    parameter int ELEM_WIDTH = 4,
    parameter int LANES      = 4,
    parameter int NUM_REGS   = 4,
    parameter int AW         = 2,
    localparam int VW        = LANES * ELEM_WIDTH
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   rd_en,
    input  logic [AW-1:0]          rd_addr,
    input  logic [NUM_REGS*VW-1:0] mem_flat,
    input  logic                   cm_en,
    input  logic [AW-1:0]          cm_addr,
    input  logic [LANES-1:0]       cm_mask,
    input  logic [VW-1:0]          cm_data,
    output logic [VW-1:0]          rd_data,
    output logic                   rd_valid
);

    logic [VW-1:0] sel;
    logic [VW-1:0] rd_data_d, rd_data_q;
    logic          rd_valid_d, rd_valid_q;

    always_comb begin
        // Out-of-range addresses match no entry and read as zero.
        sel = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (rd_addr == AW'(i)) begin
                sel = mem_flat[i*VW +: VW];
            end
        end
        // A committing write is always in range, so an address match implies
        // a valid entry.
        if (cm_en && (cm_addr == rd_addr)) begin
            sel = VW'(lane_merge(MAX_VEC_W'(sel), MAX_VEC_W'(cm_data),
                                 MAX_LANES'(cm_mask), ELEM_WIDTH, LANES));
        end
        rd_data_d  = rd_en ? sel : rd_data_q;
        rd_valid_d = rd_en;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
        end
    end

    assign rd_data  = rd_data_q;
    assign rd_valid = rd_valid_q;

endmodule

// File: rtl/vector_register_file.sv
// Vector register file: NUM_REGS entries of LANES x ELEM_WIDTH elements.
// Per-lane masked writes, two registered read ports with write bypass, and a
// sequenced re-initialise that writes the all-ones-per-element vector into
// one entry per cycle while busy is high.
// Ports:
//   clk, reset                   clock, asynchronous active-high reset
//   wr_en/wr_addr/wr_mask/wr_data  masked write (dropped while busy)
//   rd_en_a/rd_addr_a -> rd_data_a/rd_valid_a   read port A, 1-cycle latency
//   rd_en_b/rd_addr_b -> rd_data_b/rd_valid_b   read port B, 1-cycle latency
//   init_start                   pulse to start re-initialise (ignored while busy)
//   busy                         high while the re-initialise runs
//   dbg_state                    current FSM state (ST_IDLE / ST_INIT)
module vector_register_file
    import vecrf_pkg::*;
#(
    parameter int ELEM_WIDTH = 4,
    parameter int LANES      = 4,
    parameter int NUM_REGS   = 4,
    localparam int AW        = $clog2(NUM_REGS),
    localparam int VW        = LANES * ELEM_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [LANES-1:0] wr_mask,
    input  logic [VW-1:0]    wr_data,
    input  logic             rd_en_a,
    input  logic [AW-1:0]    rd_addr_a,
    output logic [VW-1:0]    rd_data_a,
    output logic             rd_valid_a,
    input  logic             rd_en_b,
    input  logic [AW-1:0]    rd_addr_b,
    output logic [VW-1:0]    rd_data_b,
    output logic             rd_valid_b,
    input  logic             init_start,
    output logic             busy,
    output logic [0:0]       dbg_state
);

    localparam logic [VW-1:0] INIT_VEC   = VW'(init_vec(ELEM_WIDTH, LANES));
    localparam logic [AW-1:0] LAST_IDX   = AW'(NUM_REGS - 1);
    localparam logic [AW:0]   NUM_REGS_W = (AW+1)'(NUM_REGS);

    logic [0:0]             state_d, state_q;
    logic [AW-1:0]          cnt_d, cnt_q;
    logic [VW-1:0]          mem_d [NUM_REGS];
    logic [VW-1:0]          mem_q [NUM_REGS];
    logic [NUM_REGS*VW-1:0] mem_flat;

    // The single write that commits at this edge: the init sequence owns the
    // write port while busy, otherwise the external write if in range.
    logic             cm_en;
    logic [AW-1:0]    cm_addr;
    logic [LANES-1:0] cm_mask;
    logic [VW-1:0]    cm_data;

    always_comb begin
        cm_en   = 1'b0;
        cm_addr = wr_addr;
        cm_mask = wr_mask;
        cm_data = wr_data;
        if (state_q == ST_INIT) begin
            cm_en   = 1'b1;
            cm_addr = cnt_q;
            cm_mask = '1;
            cm_data = INIT_VEC;
        end else if (wr_en && ({1'b0, wr_addr} < NUM_REGS_W)) begin
            cm_en = 1'b1;
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_REGS; i++) begin
            mem_d[i] = mem_q[i];
            if (cm_en && (cm_addr == AW'(i))) begin
                mem_d[i] = VW'(lane_merge(MAX_VEC_W'(mem_q[i]), MAX_VEC_W'(cm_data),
                                          MAX_LANES'(cm_mask), ELEM_WIDTH, LANES));
            end
            mem_flat[i*VW +: VW] = mem_q[i];
        end
    end

    // IDLE -> INIT on init_start; INIT walks cnt 0..NUM_REGS-1 and returns,
    // so busy is high for exactly NUM_REGS cycles.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (state_q == ST_IDLE) begin
            if (init_start) begin
                state_d = ST_INIT;
                cnt_d   = '0;
            end
        end else begin
            if (cnt_q == LAST_IDX) begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end else begin
                cnt_d = cnt_q + AW'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            for (int i = 0; i < NUM_REGS; i++) begin
                mem_q[i] <= INIT_VEC;
            end
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            for (int i = 0; i < NUM_REGS; i++) begin
                mem_q[i] <= mem_d[i];
            end
        end
    end

    vecrf_read_port #(
        .ELEM_WIDTH(ELEM_WIDTH), .LANES(LANES), .NUM_REGS(NUM_REGS), .AW(AW)
    ) u_port_a (
        .clk      (clk),
        .reset    (reset),
        .rd_en    (rd_en_a),
        .rd_addr  (rd_addr_a),
        .mem_flat (mem_flat),
        .cm_en    (cm_en),
        .cm_addr  (cm_addr),
        .cm_mask  (cm_mask),
        .cm_data  (cm_data),
        .rd_data  (rd_data_a),
        .rd_valid (rd_valid_a)
    );

    vecrf_read_port #(
        .ELEM_WIDTH(ELEM_WIDTH), .LANES(LANES), .NUM_REGS(NUM_REGS), .AW(AW)
    ) u_port_b (
        .clk      (clk),
        .reset    (reset),
        .rd_en    (rd_en_b),
        .rd_addr  (rd_addr_b),
        .mem_flat (mem_flat),
        .cm_en    (cm_en),
        .cm_addr  (cm_addr),
        .cm_mask  (cm_mask),
        .cm_data  (cm_data),
        .rd_data  (rd_data_b),
        .rd_valid (rd_valid_b)
    );

    assign busy      = (state_q == ST_INIT);
    assign dbg_state = state_q;

endmodule

// File: tb/tb_vector_register_file.sv
// Bench for vector_register_file. Two instances (NUM_REGS=4 and NUM_REGS=3)
// share all inputs; each has its own reference model and expected queues.
module tb_vector_register_file;

    logic        clk = 1'b0;
    logic        reset;
    logic        wr_en;
    logic [1:0]  wr_addr;
    logic [3:0]  wr_mask;
    logic [15:0] wr_data;
    logic        rd_en_a, rd_en_b;
    logic [1:0]  rd_addr_a, rd_addr_b;
    logic        init_start;

    logic [15:0] rd_data_a4, rd_data_b4, rd_data_a3, rd_data_b3;
    logic        rd_valid_a4, rd_valid_b4, rd_valid_a3, rd_valid_b3;
    logic        busy4, busy3;
    logic [0:0]  dbg4, dbg3;

    always #5 clk = ~clk;

    vector_register_file #(.ELEM_WIDTH(4), .LANES(4), .NUM_REGS(4)) dut4 (
        .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_mask(wr_mask),
        .wr_data(wr_data), .rd_en_a(rd_en_a), .rd_addr_a(rd_addr_a), .rd_data_a(rd_data_a4),
        .rd_valid_a(rd_valid_a4), .rd_en_b(rd_en_b), .rd_addr_b(rd_addr_b),
        .rd_data_b(rd_data_b4), .rd_valid_b(rd_valid_b4), .init_start(init_start),
        .busy(busy4), .dbg_state(dbg4)
    );

    vector_register_file #(.ELEM_WIDTH(4), .LANES(4), .NUM_REGS(3)) dut3 (
        .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_mask(wr_mask),
        .wr_data(wr_data), .rd_en_a(rd_en_a), .rd_addr_a(rd_addr_a), .rd_data_a(rd_data_a3),
        .rd_valid_a(rd_valid_a3), .rd_en_b(rd_en_b), .rd_addr_b(rd_addr_b),
        .rd_data_b(rd_data_b3), .rd_valid_b(rd_valid_b3), .init_start(init_start),
        .busy(busy3), .dbg_state(dbg3)
    );

    // ---------------- reference model and scoreboard state ----------------
    logic [15:0] m_mem [2][4];    // [0] = 4-entry file, [1] = 3-entry file
    int          m_left [2];      // remaining init cycles; >0 means busy
    int          nregs [2];
    logic [15:0] exp_q_a4[$], exp_q_b4[$], exp_q_a3[$], exp_q_b3[$];
    logic        exp_valid_a, exp_valid_b;
    logic        exp_busy [2];
    logic [15:0] hold [4];        // last value each port should be showing
    logic        mon_on;
    int          total, bad;

    function automatic logic [15:0] merge_lanes(input logic [15:0] old_v,
                                                input logic [15:0] new_v,
                                                input logic [3:0]  mask);
        logic [15:0] r;
        r = old_v;
        for (int l = 0; l < 4; l++) begin
            if (mask[l]) r[l*4 +: 4] = new_v[l*4 +: 4];
        end
        return r;
    endfunction

    task automatic push_exp(input int idx, input logic [15:0] v);
        case (idx)
            0: exp_q_a4.push_back(v);
            1: exp_q_b4.push_back(v);
            2: exp_q_a3.push_back(v);
            default: exp_q_b3.push_back(v);
        endcase
    endtask

    task automatic pop_exp(input int idx, output logic ok, output logic [15:0] v);
        ok = 1'b1;
        v  = 16'h0;
        case (idx)
            0: if (exp_q_a4.size() > 0) v = exp_q_a4.pop_front(); else ok = 1'b0;
            1: if (exp_q_b4.size() > 0) v = exp_q_b4.pop_front(); else ok = 1'b0;
            2: if (exp_q_a3.size() > 0) v = exp_q_a3.pop_front(); else ok = 1'b0;
            default: if (exp_q_b3.size() > 0) v = exp_q_b3.pop_front(); else ok = 1'b0;
        endcase
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            for (int e = 0; e < 4; e++) m_mem[k][e] = 16'h1111;
            m_left[k]   = 0;
            exp_busy[k] = 1'b0;
        end
        exp_q_a4.delete(); exp_q_b4.delete(); exp_q_a3.delete(); exp_q_b3.delete();
        for (int p = 0; p < 4; p++) hold[p] = 16'h0;
        exp_valid_a = 1'b0;
        exp_valid_b = 1'b0;
    endtask

    // The contents an entry holds after this edge is what a same-cycle read
    // returns; out-of-range reads return zero.
    task automatic model_step(input int k);
        logic [15:0] nm [4];
        int          cnt;
        for (int e = 0; e < 4; e++) nm[e] = m_mem[k][e];
        if (m_left[k] > 0) begin
            cnt     = nregs[k] - m_left[k];
            nm[cnt] = 16'h1111;
        end else if (wr_en && int'(wr_addr) < nregs[k]) begin
            nm[wr_addr] = merge_lanes(nm[wr_addr], wr_data, wr_mask);
        end
        if (rd_en_a) push_exp(k*2,     (int'(rd_addr_a) < nregs[k]) ? nm[rd_addr_a] : 16'h0);
        if (rd_en_b) push_exp(k*2 + 1, (int'(rd_addr_b) < nregs[k]) ? nm[rd_addr_b] : 16'h0);
        for (int e = 0; e < 4; e++) m_mem[k][e] = nm[e];
        if (m_left[k] > 0) m_left[k] = m_left[k] - 1;
        else if (init_start) m_left[k] = nregs[k];
    endtask

    // ---------------- driver tasks ----------------
    task automatic set_idle();
        wr_en = 1'b0; wr_addr = 2'd0; wr_mask = 4'h0; wr_data = 16'h0;
        rd_en_a = 1'b0; rd_addr_a = 2'd0; rd_en_b = 1'b0; rd_addr_b = 2'd0;
        init_start = 1'b0;
    endtask

    // Inputs are already driven (at a negedge); apply one clock edge.
    task automatic step();
        model_step(0);
        model_step(1);
        @(posedge clk);
        exp_valid_a = rd_en_a;
        exp_valid_b = rd_en_b;
        exp_busy[0] = (m_left[0] > 0);
        exp_busy[1] = (m_left[1] > 0);
        @(negedge clk);
        set_idle();
    endtask

    task automatic check_bit(input string nm, input logic got, input logic exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0b exp=%0b t=%0t", nm, got, exp, $time);
        end
    endtask

    // Mid-cycle reset: outputs must clear before the next edge.
    task automatic do_reset();
        set_idle();
        #2 reset = 1'b1;
        #1;
        check_bit("rst_busy4", busy4, 1'b0);
        check_bit("rst_busy3", busy3, 1'b0);
        check_bit("rst_valid_a4", rd_valid_a4, 1'b0);
        check_bit("rst_valid_b4", rd_valid_b4, 1'b0);
        check_bit("rst_valid_a3", rd_valid_a3, 1'b0);
        check_bit("rst_valid_b3", rd_valid_b3, 1'b0);
        model_reset();
        #1 reset = 1'b0;
        step();
    endtask

    task automatic read_all();
        for (int e = 0; e < 4; e++) begin
            rd_en_a = 1'b1; rd_addr_a = 2'(e);
            rd_en_b = 1'b1; rd_addr_b = 2'(3 - e);
            step();
        end
    endtask

    // ---------------- monitor ----------------
    task automatic check_port(input int idx, input string nm, input logic v,
                              input logic [15:0] d, input logic ev);
        logic        ok;
        logic [15:0] e;
        check_bit({nm, "_valid"}, v, ev);
        if (v === 1'b1) begin
            pop_exp(idx, ok, e);
            total++;
            if (!ok) begin
                bad++;
                $display("FAIL %s_unexpected got=%h exp=none t=%0t", nm, d, $time);
            end else begin
                hold[idx] = e;
            end
        end
        total++;
        if (d !== hold[idx]) begin
            bad++;
            $display("FAIL %s_data got=%h exp=%h t=%0t", nm, d, hold[idx], $time);
        end
    endtask

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (mon_on) begin
                check_port(0, "a4", rd_valid_a4, rd_data_a4, exp_valid_a);
                check_port(1, "b4", rd_valid_b4, rd_data_b4, exp_valid_b);
                check_port(2, "a3", rd_valid_a3, rd_data_a3, exp_valid_a);
                check_port(3, "b3", rd_valid_b3, rd_data_b3, exp_valid_b);
                check_bit("busy4", busy4, exp_busy[0]);
                check_bit("busy3", busy3, exp_busy[1]);
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        total    = 0;
        bad      = 0;
        mon_on   = 1'b0;
        nregs[0] = 4;
        nregs[1] = 3;
        set_idle();
        model_reset();
        reset = 1'b1;
        @(negedge clk);
        check_bit("reset_busy", busy4, 1'b0);
        check_bit("reset_valid", rd_valid_a4, 1'b0);
        total++;
        if (rd_data_a4 !== 16'h0 || rd_data_b4 !== 16'h0) begin
            bad++;
            $display("FAIL reset_data got=%h/%h exp=0000", rd_data_a4, rd_data_b4);
        end
        reset  = 1'b0;
        mon_on = 1'b1;

        // Reset contents on every entry
        for (int e = 0; e < 4; e++) begin
            rd_en_a = 1'b1; rd_addr_a = 2'(e);
            step();
        end
        step();

        // Masked write with same-cycle bypass on B, then normal read on A
        wr_en = 1'b1; wr_addr = 2'd2; wr_mask = 4'b0101; wr_data = 16'hABCD;
        rd_en_b = 1'b1; rd_addr_b = 2'd2;
        step();
        rd_en_a = 1'b1; rd_addr_a = 2'd2;
        step();

        // Fill, re-initialise, writes during busy dropped
        for (int e = 0; e < 4; e++) begin
            wr_en = 1'b1; wr_addr = 2'(e); wr_mask = 4'hF; wr_data = 16'($urandom);
            step();
        end
        init_start = 1'b1;
        step();
        step();
        for (int c = 0; c < 4; c++) begin
            wr_en = 1'b1; wr_addr = 2'd0; wr_mask = 4'hF; wr_data = 16'hFFFF;
            init_start = 1'b1;
            rd_en_a = 1'b1; rd_addr_a = 2'(c);
            step();
        end
        step();
        read_all();

        // Write and init_start together
        wr_en = 1'b1; wr_addr = 2'd1; wr_mask = 4'hF; wr_data = 16'hFFFF; init_start = 1'b1;
        step();
        rd_en_a = 1'b1; rd_addr_a = 2'd1;
        step();
        repeat (4) step();
        rd_en_a = 1'b1; rd_addr_a = 2'd1;
        step();

        // Reset during INIT at cnt=1
        for (int e = 0; e < 4; e++) begin
            wr_en = 1'b1; wr_addr = 2'(e); wr_mask = 4'hF; wr_data = 16'hC3C3 ^ 16'(e);
            step();
        end
        init_start = 1'b1;
        step();
        rd_en_a = 1'b1; rd_addr_a = 2'd0; rd_en_b = 1'b1; rd_addr_b = 2'd3;
        step();
        do_reset();
        read_all();

        // Address 3: out of range for the 3-entry file
        wr_en = 1'b1; wr_addr = 2'd3; wr_mask = 4'hF; wr_data = 16'h5A5A;
        rd_en_a = 1'b1; rd_addr_a = 2'd3;
        step();
        rd_en_a = 1'b1; rd_addr_a = 2'd3; rd_en_b = 1'b1; rd_addr_b = 2'd3;
        step();

        // Randomised traffic
        for (int n = 0; n < 400; n++) begin
            wr_en      = 1'($urandom_range(0, 1));
            wr_addr    = 2'($urandom_range(0, 3));
            wr_mask    = 4'($urandom_range(0, 15));
            wr_data    = 16'($urandom);
            rd_en_a    = 1'($urandom_range(0, 1));
            rd_addr_a  = 2'($urandom_range(0, 3));
            rd_en_b    = 1'($urandom_range(0, 1));
            rd_addr_b  = 2'($urandom_range(0, 3));
            init_start = ($urandom_range(0, 15) == 0);
            if ($urandom_range(0, 99) == 0) do_reset();
            else step();
        end
        step();
        step();

        total++;
        if (exp_q_a4.size() + exp_q_b4.size() + exp_q_a3.size() + exp_q_b3.size() != 0) begin
            bad++;
            $display("FAIL leftover_expected got=%0d exp=0",
                     exp_q_a4.size() + exp_q_b4.size() + exp_q_a3.size() + exp_q_b3.size());
        end
        mon_on = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
